instr_decoder_q: RTL and testbench
==================================

Name: instr_decoder_q

Overview:
Parametrised successor to the 8-bit instruction decoder. It adds a prefetch queue in front of the instruction register, plus valid/ready fetch handshake, execute-stage stall and jump flush. It sits between program-memory fetch and the datapath and produces the same control set: register enables, source select, x/y/i selects, jumps and NOP flags. All decode is qualified by instruction validity.

Parameters:
DEPTH, 4, prefetch queue entries; power of 2, minimum 2.
PTR_W, 2, queue pointer width; must equal log2(DEPTH).
BYPASS, 1, 1 = an instruction arriving at an empty queue loads IR on the same edge; 0 = it always passes through the queue (+1 cycle).

Ports:
clk  input  1  system clock; all state updates on rising edge.
sync_reset  input  1  synchronous, active-high reset.
next_instr  input  8  fetched instruction.
instr_valid  input  1  next_instr is valid this cycle.
instr_ready  output  1  queue can accept; a push occurs when instr_valid && instr_ready.
stall  input  1  execute stage holds; IR must not advance.
flush  input  1  taken jump; discard queue and IR contents.
ir  output  8  instruction register.
ir_valid  output  1  ir holds a live instruction.
ir_nibble  output  4  ir[3:0].
reg_en  output  9  [0]x0 [1]x1 [2]y0 [3]y1 [4]r [5]m [6]i [7]dm [8]o_reg.
source_sel  output  4  data-bus source: 0-7 register, 8 immediate, 9 i_pins, 10 zero.
i_sel, x_sel, y_sel  output  1 each  ALU and index selects.
jmp, jmp_nz  output  1 each  unconditional and not-zero jump.
nop  output  1  ir is C8, CF, D8 or DF and ir_valid.
q_count  output  PTR_W+1  queue occupancy, 0..DEPTH.

Behaviour:
- Reset (sync_reset=1 at an edge): queue emptied (q_count=0), ir=8'h00, ir_valid=0.
- While sync_reset=1, outputs are forced combinationally: reg_en=9'h1FF, source_sel=10, jmp/jmp_nz/i_sel/x_sel/y_sel/nop=0, instr_ready=0.
- Reset mid-operation drops all queued instructions; no partial state survives.
- instr_ready = !sync_reset && !flush && (q_count < DEPTH). There is no push-when-full, even with a simultaneous pop.
- advance = !stall. On an edge with advance=1:
  - queue non-empty: IR <= head, pop, ir_valid=1.
  - queue empty, push present, BYPASS=1: IR <= next_instr directly, no queue write.
  - otherwise ir_valid <= 0.
- On an edge with advance=0: IR and ir_valid hold; any push goes to the queue.
- Simultaneous push and pop while non-empty: both occur, q_count unchanged, FIFO order preserved. Pointers wrap modulo DEPTH.
- flush=1 (priority below reset, above everything else): at the edge, q_count=0 and ir_valid=0; any same-cycle fetch is dropped (instr_ready is already 0). flush overrides stall.
- Decode is combinational from ir. It is active only when ir_valid=1 && stall=0; otherwise reg_en=0, jmp=jmp_nz=0, source_sel=10, nop=0 (selects may take any value).
- An instruction therefore executes exactly once: in the first cycle it is valid with stall=0.
- Encoding:
  - 0ddd_kkkk: load immediate; source_sel=8; enable for dest ddd (0-3→x0..y1, 4→o_reg, 5→m, 6→i, 7→dm+i).
  - 10dd_dsss: move; source_sel=sss. Exceptions: ddd==sss==4 → source_sel=4; other ddd==sss → source_sel=9. Dest enable as for load. sss=7 additionally sets reg_en[6].
  - 110x_xxxx: ALU op; reg_en[4]=1; x_sel=ir[4], y_sel=ir[3].
  - 1110_xxxx: jmp=1. 1111_xxxx: jmp_nz=1.
  - i_sel=0 for 0110_xxxx and 10110_xxx; 1 otherwise.
- Latency: fetch to decode = 1 cycle with bypass from empty; 1 + q_count cycles otherwise (no stall).

Test Plan:
- Reset: assert sync_reset for 2 cycles with instr_valid=1 → reg_en=1FF, source_sel=10, q_count=0, instr_ready=0; after release ir_valid=0 and reg_en=000.
- Bypass: from empty, push 8'h05 → next cycle ir=05, ir_valid=1, reg_en=001, source_sel=8, ir_nibble=5.
- Fill/backpressure: stall=1, push 6 instructions → q_count reaches 4, instr_ready=0; release stall → 4 instructions drain in push order, one per cycle.
- Stall mid-stream: ir=8'hA3 with stall=1 for 3 cycles → reg_en=000 while stalled; reg_en=100 (o_reg), source_sel=3 for exactly one cycle after release.
- Flush: queue holds 3 entries, ir=8'hE2 (jmp=1); assert flush with instr_valid=1 → next cycle q_count=0, ir_valid=0, the new fetch is dropped.
- Special decode: ir=8'hA4 → source_sel=4; ir=8'h9B → source_sel=9, reg_en=008; ir=8'hCF → nop=1, reg_en=010; ir=8'h87 → reg_en=041.

Source files
------------

// File: rtl/instr_decoder_q.sv
// Instruction decoder with a prefetch queue in front of the instruction register.
// The fetch side uses a valid/ready handshake; the execute side can stall or flush.
module instr_decoder_q #(
    parameter int DEPTH  = 4,
    parameter int PTR_W  = 2,
    parameter bit BYPASS = 1'b1
) (
    input  logic             clk,
    input  logic             sync_reset,
    input  logic [7:0]       next_instr,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic             stall,
    input  logic             flush,
    output logic [7:0]       ir,
    output logic             ir_valid,
    output logic [3:0]       ir_nibble,
    output logic [8:0]       reg_en,
    output logic [3:0]       source_sel,
    output logic             i_sel,
    output logic             x_sel,
    output logic             y_sel,
    output logic             jmp,
    output logic             jmp_nz,
    output logic             nop,
    output logic [PTR_W:0]   q_count
);

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);
    localparam logic [3:0]     SRC_IMM  = 4'd8;
    localparam logic [3:0]     SRC_PINS = 4'd9;
    localparam logic [3:0]     SRC_ZERO = 4'd10;

    logic [7:0]       mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic [7:0]       ir_q;
    logic             ir_valid_q;

    logic push;
    logic advance;
    logic q_empty;
    logic pop;
    logic bypass_take;
    logic q_write;

    assign instr_ready = !sync_reset && !flush && (count_q < FULL_CNT);
    assign push        = instr_valid && instr_ready;
    assign advance     = !stall;
    assign q_empty     = (count_q == '0);
    assign pop         = advance && !q_empty;
    assign bypass_take = BYPASS && advance && q_empty && push;
    assign q_write     = push && !bypass_take;

    // Queue storage: one register per entry, written only when the write pointer selects it.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (q_write && (wr_ptr_q == PTR_W'(gi))) begin
                    mem_q[gi] <= next_instr;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (sync_reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ir_q       <= 8'h00;
            ir_valid_q <= 1'b0;
        end else if (flush) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ir_valid_q <= 1'b0;
        end else begin
            if (q_write) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({q_write, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            if (advance) begin
                if (pop) begin
                    ir_q       <= mem_q[rd_ptr_q];
                    ir_valid_q <= 1'b1;
                end else if (bypass_take) begin
                    ir_q       <= next_instr;
                    ir_valid_q <= 1'b1;
                end else begin
                    ir_valid_q <= 1'b0;
                end
            end
        end
    end

    assign ir        = ir_q;
    assign ir_valid  = ir_valid_q;
    assign ir_nibble = ir_q[3:0];
    assign q_count   = count_q;

    // Destination code to register enable; code 7 writes dm and i together.
    function automatic logic [8:0] dest_en(input logic [2:0] ddd);
        logic [8:0] en;
        en = '0;
        case (ddd)
            3'd0:    en[0] = 1'b1;
            3'd1:    en[1] = 1'b1;
            3'd2:    en[2] = 1'b1;
            3'd3:    en[3] = 1'b1;
            3'd4:    en[8] = 1'b1;
            3'd5:    en[5] = 1'b1;
            3'd6:    en[6] = 1'b1;
            default: begin
                en[7] = 1'b1;
                en[6] = 1'b1;
            end
        endcase
        return en;
    endfunction

    always_comb begin
        reg_en     = '0;
        source_sel = SRC_ZERO;
        jmp        = 1'b0;
        jmp_nz     = 1'b0;
        nop        = 1'b0;
        x_sel      = ir_q[4];
        y_sel      = ir_q[3];
        i_sel      = !((ir_q[7:4] == 4'b0110) || (ir_q[7:3] == 5'b10110));
        if (sync_reset) begin
            reg_en = 9'h1FF;
            x_sel  = 1'b0;
            y_sel  = 1'b0;
            i_sel  = 1'b0;
        end else if (ir_valid_q && !stall) begin
            if (!ir_q[7]) begin
                source_sel = SRC_IMM;
                reg_en     = dest_en(ir_q[6:4]);
            end else if (!ir_q[6]) begin
                reg_en = dest_en(ir_q[5:3]);
                if (ir_q[2:0] == 3'd7) begin
                    reg_en[6] = 1'b1;
                end
                // A move onto itself is repurposed: 4->4 reads source 4, others read the pins.
                if (ir_q[5:3] != ir_q[2:0]) begin
                    source_sel = {1'b0, ir_q[2:0]};
                end else if (ir_q[2:0] == 3'd4) begin
                    source_sel = 4'd4;
                end else begin
                    source_sel = SRC_PINS;
                end
            end else if (!ir_q[5]) begin
                reg_en[4] = 1'b1;
                nop       = (ir_q[4:0] == 5'h08) || (ir_q[4:0] == 5'h0F) ||
                            (ir_q[4:0] == 5'h18) || (ir_q[4:0] == 5'h1F);
            end else if (!ir_q[4]) begin
                jmp = 1'b1;
            end else begin
                jmp_nz = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_instr_decoder_q.sv
// Bench for instr_decoder_q: a table of decode vectors, directed queue sequences,
// and random traffic checked against a queue-based reference model.
module tb_instr_decoder_q;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       sync_reset;
    logic [7:0] next_instr;
    logic       instr_valid;
    logic       instr_ready;
    logic       stall;
    logic       flush;
    logic [7:0] ir;
    logic       ir_valid;
    logic [3:0] ir_nibble;
    logic [8:0] reg_en;
    logic [3:0] source_sel;
    logic       i_sel, x_sel, y_sel, jmp, jmp_nz, nop;
    logic [2:0] q_count;

    instr_decoder_q #(.DEPTH(4), .PTR_W(2), .BYPASS(1'b1)) dut (
        .clk(clk), .sync_reset(sync_reset), .next_instr(next_instr),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .stall(stall),
        .flush(flush), .ir(ir), .ir_valid(ir_valid), .ir_nibble(ir_nibble),
        .reg_en(reg_en), .source_sel(source_sel), .i_sel(i_sel), .x_sel(x_sel),
        .y_sel(y_sel), .jmp(jmp), .jmp_nz(jmp_nz), .nop(nop), .q_count(q_count)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference state: queue contents, instruction register, valid flag.
    logic [7:0] m_q[$];
    logic [7:0] m_ir;
    bit         m_irv;

    logic [8:0] DEST_EN [8] = '{9'h001, 9'h002, 9'h004, 9'h008, 9'h100, 9'h020, 9'h040, 9'h0C0};

    typedef struct {
        logic [7:0] instr;
        logic [8:0] ren;
        logic [3:0] src;     // 4'hF: value not defined for this opcode
        bit         j;
        bit         jnz;
        bit         n;
        bit         isel;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all();
        logic [8:0] e_ren;
        logic [3:0] e_src;
        bit src_care, isel_care, xy_care;
        bit e_j, e_jnz, e_nop, e_isel, e_xs, e_ys;
        int d, s;
        e_ren = '0; e_src = 4'd10; src_care = 1; isel_care = 0; xy_care = 0;
        e_j = 0; e_jnz = 0; e_nop = 0; e_isel = 0; e_xs = 0; e_ys = 0;
        if (sync_reset) begin
            e_ren = 9'h1FF; isel_care = 1; xy_care = 1;
        end else if (m_irv && !stall) begin
            isel_care = 1;
            e_isel = !(((m_ir >> 4) == 6) || ((m_ir >> 3) == 22));
            if (m_ir < 128) begin
                e_ren = DEST_EN[(m_ir >> 4) & 7];
                e_src = 4'd8;
            end else if (m_ir < 192) begin
                d = (m_ir >> 3) & 7;
                s = m_ir & 7;
                e_ren = DEST_EN[d];
                if (s == 7) e_ren = e_ren | 9'h040;
                if (d != s)      e_src = 4'(s);
                else if (d == 4) e_src = 4'd4;
                else             e_src = 4'd9;
            end else if (m_ir < 224) begin
                e_ren = 9'h010; src_care = 0; xy_care = 1;
                e_xs = m_ir[4]; e_ys = m_ir[3];
                e_nop = (m_ir == 8'hC8) || (m_ir == 8'hCF) || (m_ir == 8'hD8) || (m_ir == 8'hDF);
            end else if (m_ir < 240) begin
                e_j = 1; src_care = 0;
            end else begin
                e_jnz = 1; src_care = 0;
            end
        end
        chk("ir_valid", 32'(ir_valid), 32'(m_irv));
        if (m_irv || sync_reset) chk("ir", 32'(ir), 32'(m_ir));
        if (m_irv) chk("ir_nibble", 32'(ir_nibble), 32'(m_ir[3:0]));
        chk("q_count", 32'(q_count), 32'(m_q.size()));
        chk("instr_ready", 32'(instr_ready),
            32'(!sync_reset && !flush && (m_q.size() < DEPTH)));
        chk("reg_en", 32'(reg_en), 32'(e_ren));
        if (src_care) chk("source_sel", 32'(source_sel), 32'(e_src));
        chk("jmp", 32'(jmp), 32'(e_j));
        chk("jmp_nz", 32'(jmp_nz), 32'(e_jnz));
        chk("nop", 32'(nop), 32'(e_nop));
        if (isel_care) chk("i_sel", 32'(i_sel), 32'(e_isel));
        if (xy_care) begin
            chk("x_sel", 32'(x_sel), 32'(e_xs));
            chk("y_sel", 32'(y_sel), 32'(e_ys));
        end
    endtask

    task automatic model_update();
        bit ready, push;
        ready = !sync_reset && !flush && (m_q.size() < DEPTH);
        push  = instr_valid && ready;
        if (sync_reset) begin
            m_q.delete(); m_ir = 8'h00; m_irv = 0;
        end else if (flush) begin
            m_q.delete(); m_irv = 0;
        end else if (!stall) begin
            if (m_q.size() > 0) begin
                m_ir = m_q.pop_front(); m_irv = 1;
                if (push) m_q.push_back(next_instr);
            end else if (push) begin
                m_ir = next_instr; m_irv = 1;
            end else begin
                m_irv = 0;
            end
        end else if (push) begin
            m_q.push_back(next_instr);
        end
    endtask

    task automatic drive(input bit rst, input bit v, input logic [7:0] d, input bit st, input bit fl);
        @(negedge clk);
        sync_reset = rst; instr_valid = v; next_instr = d; stall = st; flush = fl;
        #1;
        check_all();
        $display("t=%0t rst=%0b v=%0b d=%02h st=%0b fl=%0b | rdy=%0b ir=%02h irv=%0b q=%0d ren=%03h src=%0d j=%0b jnz=%0b nop=%0b",
                 $time, rst, v, d, st, fl, instr_ready, ir, ir_valid, q_count, reg_en, source_sel, jmp, jmp_nz, nop);
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
    endtask

    vec_t vecs[16];
    logic [7:0] fill_vals[6];

    initial begin
        vecs[0]  = '{8'h05, 9'h001, 4'd8,  0, 0, 0, 1};
        vecs[1]  = '{8'hA4, 9'h100, 4'd4,  0, 0, 0, 1};
        vecs[2]  = '{8'h9B, 9'h008, 4'd9,  0, 0, 0, 1};
        vecs[3]  = '{8'hCF, 9'h010, 4'hF,  0, 0, 1, 1};
        vecs[4]  = '{8'h87, 9'h041, 4'd7,  0, 0, 0, 1};
        vecs[5]  = '{8'hA3, 9'h100, 4'd3,  0, 0, 0, 1};
        vecs[6]  = '{8'hE2, 9'h000, 4'hF,  1, 0, 0, 1};
        vecs[7]  = '{8'hF5, 9'h000, 4'hF,  0, 1, 0, 1};
        vecs[8]  = '{8'h70, 9'h0C0, 4'd8,  0, 0, 0, 1};
        vecs[9]  = '{8'hB1, 9'h040, 4'd1,  0, 0, 0, 0};
        vecs[10] = '{8'hB6, 9'h040, 4'd9,  0, 0, 0, 0};
        vecs[11] = '{8'hBF, 9'h0C0, 4'd9,  0, 0, 0, 1};
        vecs[12] = '{8'hD8, 9'h010, 4'hF,  0, 0, 1, 1};
        vecs[13] = '{8'hC9, 9'h010, 4'hF,  0, 0, 0, 1};
        vecs[14] = '{8'h4A, 9'h100, 4'd8,  0, 0, 0, 1};
        vecs[15] = '{8'h6A, 9'h040, 4'd8,  0, 0, 0, 0};
        fill_vals = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};

        sync_reset = 1; instr_valid = 0; next_instr = 0; stall = 0; flush = 0;
        m_ir = 8'h00; m_irv = 0;
        // Bring the design out of its unknown power-up state before any checking.
        @(posedge clk);
        model_update();

        // Reset held with fetch valid
        drive(1, 1, 8'h99, 0, 0);
        chk("rst_reg_en", 32'(reg_en), 32'h1FF);
        chk("rst_src", 32'(source_sel), 32'd10);
        chk("rst_ready", 32'(instr_ready), 32'd0);
        tick();
        drive(1, 1, 8'h98, 0, 0);
        chk("rst_qcount", 32'(q_count), 32'd0);
        tick();
        drive(0, 0, 8'h00, 0, 0);
        chk("post_rst_irv", 32'(ir_valid), 32'd0);
        chk("post_rst_ren", 32'(reg_en), 32'h000);
        tick();

        // Bypass from empty
        drive(0, 1, 8'h05, 0, 0);
        tick();
        drive(0, 0, 8'h00, 0, 0);
        chk("byp_ir", 32'(ir), 32'h05);
        chk("byp_irv", 32'(ir_valid), 32'd1);
        chk("byp_ren", 32'(reg_en), 32'h001);
        chk("byp_src", 32'(source_sel), 32'd8);
        chk("byp_nib", 32'(ir_nibble), 32'd5);
        tick();

        // Decode table, each instruction bypassed into IR from an empty queue
        for (int k = 0; k < 16; k++) begin
            drive(0, 1, vecs[k].instr, 0, 0);
            tick();
            drive(0, 0, 8'h00, 0, 0);
            chk("tbl_ren", 32'(reg_en), 32'(vecs[k].ren));
            if (vecs[k].src != 4'hF) chk("tbl_src", 32'(source_sel), 32'(vecs[k].src));
            chk("tbl_jmp", 32'(jmp), 32'(vecs[k].j));
            chk("tbl_jnz", 32'(jmp_nz), 32'(vecs[k].jnz));
            chk("tbl_nop", 32'(nop), 32'(vecs[k].n));
            chk("tbl_isel", 32'(i_sel), 32'(vecs[k].isel));
            tick();
        end

        // Fill under stall, then drain in push order
        for (int k = 0; k < 6; k++) begin
            drive(0, 1, fill_vals[k], 1, 0);
            if (k >= 4) begin
                chk("fill_q4", 32'(q_count), 32'd4);
                chk("fill_rdy", 32'(instr_ready), 32'd0);
            end
            tick();
        end
        for (int k = 0; k < 5; k++) begin
            drive(0, 0, 8'h00, 0, 0);
            if (k > 0) begin
                chk("drain_ir", 32'(ir), 32'(fill_vals[k-1]));
                chk("drain_irv", 32'(ir_valid), 32'd1);
                chk("drain_q", 32'(q_count), 32'(4 - k));
            end
            tick();
        end

        // Stall mid-stream on A3
        drive(0, 1, 8'hA3, 0, 0);
        tick();
        for (int k = 0; k < 3; k++) begin
            drive(0, 0, 8'h00, 1, 0);
            chk("stall_ren", 32'(reg_en), 32'h000);
            chk("stall_ir", 32'(ir), 32'hA3);
            tick();
        end
        drive(0, 0, 8'h00, 0, 0);
        chk("rel_ren", 32'(reg_en), 32'h100);
        chk("rel_src", 32'(source_sel), 32'd3);
        tick();
        drive(0, 0, 8'h00, 0, 0);
        chk("once_ren", 32'(reg_en), 32'h000);
        chk("once_irv", 32'(ir_valid), 32'd0);
        tick();

        // Flush with three queued entries and a jump in IR
        drive(0, 1, 8'hE2, 0, 0);
        tick();
        for (int k = 1; k <= 3; k++) begin
            drive(0, 1, 8'(k), 1, 0);
            tick();
        end
        drive(0, 1, 8'h77, 0, 1);
        chk("fl_q3", 32'(q_count), 32'd3);
        chk("fl_jmp", 32'(jmp), 32'd1);
        chk("fl_rdy", 32'(instr_ready), 32'd0);
        tick();
        for (int k = 0; k < 2; k++) begin
            drive(0, 0, 8'h00, 0, 0);
            chk("fl_q0", 32'(q_count), 32'd0);
            chk("fl_irv", 32'(ir_valid), 32'd0);
            tick();
        end

        // Random traffic against the reference model
        for (int k = 0; k < 600; k++) begin
            drive(($urandom_range(0, 49) == 0), ($urandom_range(0, 2) != 0), 8'($urandom),
                  ($urandom_range(0, 2) == 0), ($urandom_range(0, 11) == 0));
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
